// File: rtl/bht_update_ctrl.sv
// Branch history table update controller: sweeps the table to weakly-taken, then drains
// resolved branches from a small FIFO into read-modify-write 2-bit saturating counter updates.
module bht_update_ctrl #(
    parameter int BHT_WIDTH   = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_to_ctrl_ready,
    input  logic [31:0]          rob_to_ctrl_pc,
    input  logic                 rob_to_ctrl_actual_br,
    output logic                 ctrl_to_rob_full,
    input  logic                 clr_req,
    output logic                 ctrl_busy,
    output logic                 ctrl_to_bht_we,
    output logic [BHT_WIDTH-1:0] ctrl_to_bht_idx,
    output logic [1:0]           ctrl_to_bht_wdata,
    input  logic [1:0]           bht_to_ctrl_rdata,
    output logic [7:0]           drop_cnt
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BHT_WIDTH-1:0] sweep_q, sweep_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           drop_q, drop_d;

    logic [BHT_WIDTH-1:0] ent_idx_q [QUEUE_DEPTH];
    logic                 ent_br_q  [QUEUE_DEPTH];

    logic                 full;
    logic                 push_ok;
    logic                 drop_evt;
    logic                 pop;
    logic [BHT_WIDTH-1:0] head_idx;
    logic                 head_br;
    logic [1:0]           sat_val;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{rob_to_ctrl_pc[31:BHT_WIDTH+2], rob_to_ctrl_pc[1:0]};

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign full     = (count_q == CW'(QUEUE_DEPTH));
    assign push_ok  = rdy_in & rob_to_ctrl_ready & ~clr_req & ~full;
    assign drop_evt = rdy_in & rob_to_ctrl_ready & ~clr_req & full;
    assign pop      = rdy_in & (state_q == RUN) & (count_q != '0);

    assign head_idx = ent_idx_q[head_q];
    assign head_br  = ent_br_q[head_q];

    always_comb begin
        sat_val = bht_to_ctrl_rdata;
        if (head_br) begin
            if (bht_to_ctrl_rdata != 2'b11) sat_val = bht_to_ctrl_rdata + 2'd1;
        end else begin
            if (bht_to_ctrl_rdata != 2'b00) sat_val = bht_to_ctrl_rdata - 2'd1;
        end
    end

    // Write enable is gated by reset so the table is never written while reset is held.
    always_comb begin
        ctrl_to_bht_we    = 1'b0;
        ctrl_to_bht_idx   = sweep_q;
        ctrl_to_bht_wdata = 2'b10;
        if (state_q == INIT) begin
            ctrl_to_bht_we = rst_in & rdy_in;
        end else if (count_q != '0) begin
            ctrl_to_bht_we    = rst_in & rdy_in;
            ctrl_to_bht_idx   = head_idx;
            ctrl_to_bht_wdata = sat_val;
        end else begin
            ctrl_to_bht_idx   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (rdy_in) begin
            if (clr_req) begin
                state_d = INIT;
                sweep_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (state_q == INIT) begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == '1) state_d = RUN;
                end
                if (push_ok) tail_d = tail_q + 1'b1;
                if (pop)     head_d = head_q + 1'b1;
                count_d = count_q + CW'(push_ok) - CW'(pop);
                if (drop_evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= INIT;
            sweep_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            ent_idx_q[tail_q] <= rob_to_ctrl_pc[BHT_WIDTH+1:2];
            ent_br_q[tail_q]  <= rob_to_ctrl_actual_br;
        end
    end

    assign ctrl_to_rob_full = full;
    assign ctrl_busy        = (state_q == INIT);
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with a behavioural 256-entry BHT attached.
module tb_bht_update_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_to_ctrl_ready;
    logic [31:0] rob_to_ctrl_pc;
    logic        rob_to_ctrl_actual_br;
    logic        ctrl_to_rob_full;
    logic        clr_req;
    logic        ctrl_busy;
    logic        ctrl_to_bht_we;
    logic [7:0]  ctrl_to_bht_idx;
    logic [1:0]  ctrl_to_bht_wdata;
    logic [1:0]  bht_to_ctrl_rdata;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    bht_update_ctrl #(.BHT_WIDTH(8), .QUEUE_DEPTH(4)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .rob_to_ctrl_ready    (rob_to_ctrl_ready),
        .rob_to_ctrl_pc       (rob_to_ctrl_pc),
        .rob_to_ctrl_actual_br(rob_to_ctrl_actual_br),
        .ctrl_to_rob_full     (ctrl_to_rob_full),
        .clr_req              (clr_req),
        .ctrl_busy            (ctrl_busy),
        .ctrl_to_bht_we       (ctrl_to_bht_we),
        .ctrl_to_bht_idx      (ctrl_to_bht_idx),
        .ctrl_to_bht_wdata    (ctrl_to_bht_wdata),
        .bht_to_ctrl_rdata    (bht_to_ctrl_rdata),
        .drop_cnt             (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    logic [1:0] bht_mem [256];
    always @(posedge clk_in) begin
        if (ctrl_to_bht_we) bht_mem[ctrl_to_bht_idx] <= ctrl_to_bht_wdata;
    end
    assign bht_to_ctrl_rdata = bht_mem[ctrl_to_bht_idx];

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        br;
        logic        rdy;
        logic        we;
        logic [7:0]  idx;
        logic [1:0]  wd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rv, input logic [31:0] pc, input logic br,
                                input logic rdy, input logic we, input logic [7:0] idx,
                                input logic [1:0] wd);
        vec_t v;
        v.rv = rv; v.pc = pc; v.br = br; v.rdy = rdy; v.we = we; v.idx = idx; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Leaves the caller at the falling edge of the first RUN cycle.
    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_in);
            if (!ctrl_busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    bit ok;

    initial begin
        vecs[0]  = mk(1, 32'h10, 1, 1, 0, 8'd0,   2'd0);
        vecs[1]  = mk(1, 32'h10, 1, 1, 1, 8'd4,   2'd3);
        vecs[2]  = mk(1, 32'h10, 1, 1, 1, 8'd4,   2'd3);
        vecs[3]  = mk(1, 32'h10, 0, 1, 1, 8'd4,   2'd3);
        vecs[4]  = mk(0, 32'h0,  0, 1, 1, 8'd4,   2'd2);
        vecs[5]  = mk(1, 32'h20, 1, 1, 0, 8'd0,   2'd0);
        vecs[6]  = mk(1, 32'h24, 0, 0, 0, 8'd0,   2'd0);
        vecs[7]  = mk(0, 32'h0,  0, 0, 0, 8'd0,   2'd0);
        vecs[8]  = mk(0, 32'h0,  0, 1, 1, 8'd8,   2'd3);
        vecs[9]  = mk(1, 32'h24, 0, 1, 0, 8'd0,   2'd0);
        vecs[10] = mk(0, 32'h0,  0, 1, 1, 8'd9,   2'd1);
        vecs[11] = mk(1, 32'h24, 0, 1, 0, 8'd0,   2'd0);
        vecs[12] = mk(1, 32'h24, 0, 1, 1, 8'd9,   2'd0);
        vecs[13] = mk(0, 32'h0,  0, 1, 1, 8'd9,   2'd0);
        vecs[14] = mk(1, 32'hFFFFF3FC, 1, 1, 0, 8'd0, 2'd0);
        vecs[15] = mk(0, 32'h0,  0, 1, 1, 8'd255, 2'd3);
        vecs[16] = mk(0, 32'h0,  0, 1, 0, 8'd0,   2'd0);

        rst_in = 1'b0;
        rdy_in = 1'b1;
        rob_to_ctrl_ready = 1'b0;
        rob_to_ctrl_pc = '0;
        rob_to_ctrl_actual_br = 1'b0;
        clr_req = 1'b0;

        repeat (3) step();
        chk("rst_we",    32'(ctrl_to_bht_we), 0);
        chk("rst_idx",   32'(ctrl_to_bht_idx), 0);
        chk("rst_wdata", 32'(ctrl_to_bht_wdata), 2);
        chk("rst_busy",  32'(ctrl_busy), 1);
        chk("rst_full",  32'(ctrl_to_rob_full), 0);
        chk("rst_drop",  32'(drop_cnt), 0);
        rst_in = 1'b1;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk_in);
            chk("sweep_we",    32'(ctrl_to_bht_we), 1);
            chk("sweep_idx",   32'(ctrl_to_bht_idx), 32'(i));
            chk("sweep_wdata", 32'(ctrl_to_bht_wdata), 2);
            step();
        end
        @(negedge clk_in);
        chk("sweep_done_busy", 32'(ctrl_busy), 0);
        step();

        for (int v = 0; v < NV; v++) begin
            rob_to_ctrl_ready     = vecs[v].rv;
            rob_to_ctrl_pc        = vecs[v].pc;
            rob_to_ctrl_actual_br = vecs[v].br;
            rdy_in                = vecs[v].rdy;
            @(negedge clk_in);
            chk($sformatf("vec%0d_we", v), 32'(ctrl_to_bht_we), 32'(vecs[v].we));
            if (vecs[v].we) begin
                chk($sformatf("vec%0d_idx", v), 32'(ctrl_to_bht_idx), 32'(vecs[v].idx));
                chk($sformatf("vec%0d_wdata", v), 32'(ctrl_to_bht_wdata), 32'(vecs[v].wd));
            end
            chk($sformatf("vec%0d_full", v), 32'(ctrl_to_rob_full), 0);
            chk($sformatf("vec%0d_busy", v), 32'(ctrl_busy), 0);
            step();
        end
        rob_to_ctrl_ready = 1'b0;
        rdy_in = 1'b1;

        // Overflow during INIT, then in-order drain with an rdy_in stall in the middle.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rob_to_ctrl_ready     = 1'b1;
            rob_to_ctrl_pc        = 32'((k + 1) * 4);
            rob_to_ctrl_actual_br = (k % 2 == 0);
            @(negedge clk_in);
            if (k == 0) begin
                chk("clr_busy", 32'(ctrl_busy), 1);
                chk("clr_idx",  32'(ctrl_to_bht_idx), 0);
            end
            chk($sformatf("fill%0d_full", k), 32'(ctrl_to_rob_full), 32'(k == 4));
            chk($sformatf("fill%0d_drop", k), 32'(drop_cnt), 0);
            step();
        end
        rob_to_ctrl_ready = 1'b0;
        @(negedge clk_in);
        chk("ovf_drop", 32'(drop_cnt), 1);
        chk("ovf_full", 32'(ctrl_to_rob_full), 1);
        step();
        wait_run(ok);
        chk("run_reached_1", 32'(ok), 1);
        chk("drain0_we",    32'(ctrl_to_bht_we), 1);
        chk("drain0_idx",   32'(ctrl_to_bht_idx), 1);
        chk("drain0_wdata", 32'(ctrl_to_bht_wdata), 3);
        chk("drain0_full",  32'(ctrl_to_rob_full), 1);
        step();
        @(negedge clk_in);
        chk("drain1_idx",   32'(ctrl_to_bht_idx), 2);
        chk("drain1_wdata", 32'(ctrl_to_bht_wdata), 1);
        chk("drain1_full",  32'(ctrl_to_rob_full), 0);
        step();
        rdy_in = 1'b0;
        rob_to_ctrl_ready = 1'b1;
        rob_to_ctrl_pc = 32'h40;
        rob_to_ctrl_actual_br = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_in);
            chk($sformatf("stall%0d_we", s), 32'(ctrl_to_bht_we), 0);
            chk($sformatf("stall%0d_busy", s), 32'(ctrl_busy), 0);
            step();
        end
        rdy_in = 1'b1;
        rob_to_ctrl_ready = 1'b0;
        @(negedge clk_in);
        chk("drain2_we",    32'(ctrl_to_bht_we), 1);
        chk("drain2_idx",   32'(ctrl_to_bht_idx), 3);
        chk("drain2_wdata", 32'(ctrl_to_bht_wdata), 3);
        step();
        @(negedge clk_in);
        chk("drain3_idx",   32'(ctrl_to_bht_idx), 4);
        chk("drain3_wdata", 32'(ctrl_to_bht_wdata), 1);
        step();
        @(negedge clk_in);
        chk("drain_empty_we", 32'(ctrl_to_bht_we), 0);
        chk("drain_drop",     32'(drop_cnt), 1);
        step();

        // Clear while three entries are still queued in RUN.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rob_to_ctrl_ready = 1'b1;
            rob_to_ctrl_pc = 32'h40 + 32'(k * 4);
            rob_to_ctrl_actual_br = 1'b1;
            step();
        end
        rob_to_ctrl_ready = 1'b0;
        wait_run(ok);
        chk("run_reached_2", 32'(ok), 1);
        chk("q3_head_idx", 32'(ctrl_to_bht_idx), 16);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        @(negedge clk_in);
        chk("clr_run_busy",  32'(ctrl_busy), 1);
        chk("clr_run_idx",   32'(ctrl_to_bht_idx), 0);
        chk("clr_run_wdata", 32'(ctrl_to_bht_wdata), 2);
        step();
        wait_run(ok);
        chk("run_reached_3", 32'(ok), 1);
        chk("clr_emptied_we", 32'(ctrl_to_bht_we), 0);
        step();

        // Asynchronous reset in the middle of the sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (100) step();
        @(negedge clk_in);
        chk("pre_arst_idx", 32'(ctrl_to_bht_idx), 100);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_we",   32'(ctrl_to_bht_we), 0);
        chk("arst_busy", 32'(ctrl_busy), 1);
        chk("arst_idx",  32'(ctrl_to_bht_idx), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        step();
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rel_idx", 32'(ctrl_to_bht_idx), 0);
        chk("rel_we",  32'(ctrl_to_bht_we), 1);
        step();
        @(negedge clk_in);
        chk("rel_idx_next", 32'(ctrl_to_bht_idx), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
